spi_slave_rx: RTL and testbench

SPI mode-0 responder for the far end of the team's SPI master link. It receives bytes on `mosi` and returns bytes on `miso` while `cs_n` is low. All SPI pins are oversampled in the `clk` domain, so the block has no second clock. It sits on the peripheral side of the bus, usually inside the testbench DUT wrapper opposite the SPI master.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_rx.sv | 141 ++++++++++++++
 tb/tb_spi_slave_rx.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI mode-0 responder.
// Frame width default, counter width and FSM state encoding.
package spi_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int CNT_W = $clog2(DEF_DATA_W + 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer with a previous-value flop.
// Produces the synchronized level and its rise/fall strobes.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync = sync_q[STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 responder, all pins oversampled in the clk domain.
// Receives MSB-first frames on mosi, returns tx_data on miso.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              done,
  output logic              busy,
  output logic              abort
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .sync(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  // cs_n resets high so leaving reset never looks like a select
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(cs_n),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(mosi),
    .sync(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_slv_state_t    state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              reload_q, reload_d;
  logic              miso_q, miso_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;

  logic unused_sig;
  assign unused_sig = ^{sclk_s, mosi_rise, mosi_fall, rx_sh_q[DATA_W-1]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_sh_d   = rx_sh_q;
    tx_sh_d   = tx_sh_q;
    rx_data_d = rx_data_q;
    reload_d  = reload_q;
    miso_d    = miso_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d  = ACTIVE;
          tx_sh_d  = tx_data;
          cnt_d    = '0;
          reload_d = 1'b0;
          miso_d   = tx_data[DATA_W-1];
        end
      end
      ACTIVE: begin
        if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_s};
          if (cnt_q == LAST) begin
            rx_data_d = rx_sh_d;
            done_d    = 1'b1;
            cnt_d     = '0;
            reload_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            tx_sh_d  = tx_data;
            reload_d = 1'b0;
          end else begin
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
          end
          miso_d = tx_sh_d[DATA_W-1];
        end
        // a rise in the same cycle has already updated cnt_d
        if (cs_rise) begin
          abort_d = (cnt_d != '0);
          state_d = IDLE;
          miso_d  = 1'b0;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      rx_data_q <= '0;
      reload_q  <= 1'b0;
      miso_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      rx_data_q <= rx_data_d;
      reload_q  <= reload_d;
      miso_q    <= miso_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = (state_q == ACTIVE);
  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign abort   = abort_q;
  assign busy    = ~cs_s;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx with a queue of expected RX bytes.
// clk is 8x sclk; inputs change on clk negedges.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       done;
  logic       busy;
  logic       abort;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  logic [7:0] exp_q[$];

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data),
    .rx_data(rx_data), .done(done), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // master side: mosi set on the low phase, miso sampled at the sclk rise
  task automatic xfer(input logic [7:0] b, input int nbits,
                      input bit cs_last, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      wclk(4);
      sclk = 1'b1;
      if (cs_last && i == nbits - 1) cs_n = 1'b1;
      r = {r[6:0], miso};
      wclk(4);
      sclk = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL done_unexpected: observed=%0h expected=none", rx_data);
        end
        if (exp_q.size() != 0) begin
          logic [7:0] e;
          e = exp_q.pop_front();
          checks++;
          assert (rx_data === e) else begin
            failures++;
            $error("FAIL rx_data: observed=%0h expected=%0h", rx_data, e);
          end
        end
      end
      if (abort) abort_cnt++;
      if (done || abort) begin
        checks++;
        assert (!(done && abort)) else begin
          failures++;
          $error("FAIL done_and_abort: observed=1 expected=0");
        end
      end
    end
  end

  initial begin
    logic [7:0] got;
    int d0, a0;

    wclk(3);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_rx", rx_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);
    rst = 1'b0;
    wclk(4);

    // single byte
    d0 = done_cnt; a0 = abort_cnt;
    tx_data = 8'h3C;
    cs_n = 1'b0;
    wclk(4);
    chk("t1_busy", busy, 1);
    chk("t1_oe", miso_oe, 1);
    exp_q.push_back(8'hA5);
    xfer(8'hA5, 8, 0, got);
    chk("t1_miso_byte", got, 8'h3C);
    chk("t1_busy_mid", busy, 1);
    cs_n = 1'b1;
    wclk(6);
    chk("t1_busy_end", busy, 0);
    chk("t1_oe_end", miso_oe, 0);
    chk("t1_done_n", done_cnt - d0, 1);
    chk("t1_abort_n", abort_cnt - a0, 0);

    // two bytes in one select window
    d0 = done_cnt;
    tx_data = 8'h55;
    cs_n = 1'b0;
    wclk(4);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFE);
    xfer(8'h01, 8, 0, got);
    tx_data = 8'hAA;
    chk("t2_miso_b0", got, 8'h55);
    xfer(8'hFE, 8, 0, got);
    chk("t2_miso_b1", got, 8'hAA);
    cs_n = 1'b1;
    wclk(6);
    chk("t2_done_n", done_cnt - d0, 2);

    // deselect after 5 bits
    d0 = done_cnt; a0 = abort_cnt;
    cs_n = 1'b0;
    wclk(4);
    xfer(8'h5A, 5, 0, got);
    wclk(4);
    cs_n = 1'b1;
    wclk(6);
    chk("t3_abort_n", abort_cnt - a0, 1);
    chk("t3_done_n", done_cnt - d0, 0);
    chk("t3_rx_kept", rx_data, 8'hFE);
    chk("t3_oe", miso_oe, 0);

    // cs_n rises together with the 8th sclk rise
    d0 = done_cnt; a0 = abort_cnt;
    cs_n = 1'b0;
    wclk(4);
    exp_q.push_back(8'h7E);
    xfer(8'h7E, 8, 1, got);
    wclk(6);
    chk("t4_done_n", done_cnt - d0, 1);
    chk("t4_abort_n", abort_cnt - a0, 0);
    chk("t4_rx", rx_data, 8'h7E);

    // reset mid-frame
    d0 = done_cnt; a0 = abort_cnt;
    cs_n = 1'b0;
    wclk(4);
    xfer(8'hC3, 3, 0, got);
    rst = 1'b1;
    wclk(2);
    chk("t5_rx", rx_data, 0);
    chk("t5_oe", miso_oe, 0);
    chk("t5_miso", miso, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_abort", abort, 0);
    cs_n = 1'b1;
    wclk(2);
    rst = 1'b0;
    wclk(4);
    chk("t5_no_evt", (done_cnt - d0) + (abort_cnt - a0), 0);
    tx_data = 8'h5A;
    cs_n = 1'b0;
    wclk(4);
    exp_q.push_back(8'h96);
    xfer(8'h96, 8, 0, got);
    chk("t5_miso_byte", got, 8'h5A);
    cs_n = 1'b1;
    wclk(6);
    chk("t5_rx_after", rx_data, 8'h96);

    // sclk activity while deselected
    d0 = done_cnt; a0 = abort_cnt;
    xfer(8'hFF, 8, 0, got);
    wclk(6);
    chk("t6_done_n", done_cnt - d0, 0);
    chk("t6_abort_n", abort_cnt - a0, 0);
    chk("t6_oe", miso_oe, 0);
    chk("t6_rx", rx_data, 8'h96);

    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
